// File: rtl/easy_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : easy_fifo_pkg
// Brief  : Shared types and helpers for the easy_fifo queue-drain arbiters.
// Rev    : 1.0
// ============================================================================
package easy_fifo_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Width of a queue index; at least one bit so a degenerate queue count still has a port.
    function automatic int rr_qw(input int num_q);
        return (num_q > 1) ? $clog2(num_q) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotating-priority picker; first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
module rr_pick
    import easy_fifo_pkg::*;
#(
    parameter int N = 4,
    parameter int W = rr_qw(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] w_cand;

    // Walk from the farthest candidate back to ptr so the closest match wins.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = W'((int'(ptr) + k) % N);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_rr_drain_arbiter
// Brief  : Round-robin burst drain of NUM_Q FWFT queue read ports into one
//          valid/ready stream with a registered output stage.
// Rev    : 1.0
// ============================================================================
module fifo_rr_drain_arbiter
    import easy_fifo_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int NUM_Q     = 4,
    parameter int MAX_BURST = 8,
    parameter int QW        = rr_qw(NUM_Q)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_Q-1:0]        cfg_enable,
    input  logic [NUM_Q*DWIDTH-1:0] q_rd_data,
    input  logic [NUM_Q-1:0]        q_rd_empty,
    output logic [NUM_Q-1:0]        q_rd_en,
    output logic [DWIDTH-1:0]       m_data,
    output logic [QW-1:0]           m_qid,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy
);

    localparam int             CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [QW-1:0]  c_LAST_Q   = QW'(NUM_Q - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [QW-1:0]       r_ptr;
    logic [QW-1:0]       r_grant;
    logic [CW-1:0]       r_cnt;
    logic [DWIDTH-1:0]   r_m_data;
    logic [QW-1:0]       r_m_qid;
    logic                r_m_valid;

    logic [NUM_Q-1:0]    w_req;
    logic                w_adv;
    logic                w_pop;
    logic                w_burst_end;
    logic                w_found;
    logic [QW-1:0]       w_idx;
    logic [DWIDTH-1:0]   w_qdata [NUM_Q];

    assign w_req = ~q_rd_empty & cfg_enable;
    assign w_adv = ~r_m_valid | m_ready;

    generate
        for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_unpack
            assign w_qdata[gi] = q_rd_data[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    rr_pick #(
        .N (NUM_Q),
        .W (QW)
    ) u_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pops are gated by rst so a reset landing mid-burst removes nothing more from the queue.
    always_comb begin
        w_state_nxt = r_state;
        q_rd_en     = '0;
        w_pop       = 1'b0;
        w_burst_end = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ARB_BURST;
                end
            end
            ARB_BURST: begin
                w_pop       = w_req[r_grant] & w_adv & ~rst;
                w_burst_end = ~w_req[r_grant] | (w_pop & (r_cnt == c_CNT_LAST));
                if (w_pop) begin
                    q_rd_en[r_grant] = 1'b1;
                end
                if (w_burst_end) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_m_data  <= '0;
            r_m_qid   <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if ((r_state == ARB_IDLE) && w_found) begin
                r_grant <= w_idx;
                r_cnt   <= '0;
            end
            if (w_pop) begin
                r_m_data  <= w_qdata[r_grant];
                r_m_qid   <= r_grant;
                r_m_valid <= 1'b1;
                r_cnt     <= r_cnt + CW'(1);
            end else if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_burst_end) begin
                r_ptr <= (r_grant == c_LAST_Q) ? '0 : r_grant + QW'(1);
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_qid   = r_m_qid;
    assign m_valid = r_m_valid;
    assign busy    = (r_state == ARB_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_drain_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_rr_drain_arbiter
// Brief  : Directed self-checking bench with FWFT queue models and an output log.
// Rev    : 1.0
// ============================================================================
module tb_fifo_rr_drain_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   cfg_enable = 4'hF;
    logic [127:0] q_rd_data = '0;
    logic [3:0]   q_rd_empty = 4'hF;
    logic [3:0]   q_rd_en;
    logic [31:0]  m_data;
    logic [1:0]   m_qid;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic         busy;

    always #5 clk = ~clk;

    fifo_rr_drain_arbiter #(
        .DWIDTH    (32),
        .NUM_Q     (4),
        .MAX_BURST (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_enable (cfg_enable),
        .q_rd_data  (q_rd_data),
        .q_rd_empty (q_rd_empty),
        .q_rd_en    (q_rd_en),
        .m_data     (m_data),
        .m_qid      (m_qid),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    logic [31:0] mem [4][256];
    int          head [4] = '{0, 0, 0, 0};
    int          tail [4] = '{0, 0, 0, 0};
    int          viol = 0;
    int          cyc  = 0;
    logic [31:0] rx_data [$];
    logic [1:0]  rx_qid  [$];
    int          rx_cyc  [$];
    logic [31:0] exp_d   [$];
    logic [1:0]  exp_q   [$];
    int          nchk  = 0;
    int          npass = 0;

    // FWFT queue models: pop on q_rd_en, then present the new head word.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (q_rd_en[i]) begin
                if (head[i] >= tail[i]) viol++;
                else head[i]++;
            end
        end
        if ((q_rd_en & (q_rd_en - 4'd1)) != 4'd0) viol++;
        for (int i = 0; i < 4; i++) begin
            q_rd_empty[i]         <= (head[i] >= tail[i]);
            q_rd_data[i*32 +: 32] <= (head[i] < tail[i]) ? mem[i][head[i]] : 32'h0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst && m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_qid.push_back(m_qid);
            rx_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] mkw(input int q, input int n);
        return {8'(q), 24'(n)};
    endfunction

    task automatic push(input int q, input int n0, input int n);
        for (int k = 0; k < n; k++) begin
            mem[q][tail[q]] = mkw(q, n0 + k);
            tail[q]++;
        end
    endtask

    task automatic exp_burst(input int q, input int n0, input int n);
        for (int k = 0; k < n; k++) begin
            exp_d.push_back(mkw(q, n0 + k));
            exp_q.push_back(2'(q));
        end
    endtask

    function automatic int first_bad(input int base);
        for (int i = 0; i < exp_d.size(); i++) begin
            if (base + i >= rx_data.size()) return i;
            if (rx_data[base + i] !== exp_d[i] || rx_qid[base + i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rx_at(input int idx);
        return (idx < rx_data.size()) ? rx_data[idx] : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (rx_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        m_ready    = 1'b1;
        cfg_enable = 4'hF;
        for (int i = 0; i < 4; i++) tail[i] = head[i];
        exp_d.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nchk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b need 0", m_valid); else npass++;
        nchk++; if (m_data !== 32'h0) $display("FAIL reset_m_data got %h need 0", m_data); else npass++;
        nchk++; if (m_qid !== 2'd0) $display("FAIL reset_m_qid got %0d need 0", m_qid); else npass++;
        nchk++; if (q_rd_en !== 4'h0) $display("FAIL reset_q_rd_en got %b need 0000", q_rd_en); else npass++;
        nchk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b need 0", busy); else npass++;
        rst = 1'b0;
    endtask

    task automatic test_single_queue();
        do_reset();
        push(0, 0, 3);
        @(negedge clk);
        @(negedge clk);
        nchk++; if (busy !== 1'b1) $display("FAIL single_busy got %b need 1", busy); else npass++;
        nchk++; if (m_valid !== 1'b0) $display("FAIL single_pick_valid got %b need 0", m_valid); else npass++;
        nchk++; if (q_rd_en !== 4'b0001) $display("FAIL single_pop got %b need 0001", q_rd_en); else npass++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nchk++;
            if (m_valid !== 1'b1 || m_data !== mkw(0, k) || m_qid !== 2'd0)
                $display("FAIL single_word%0d got v=%b %h q%0d need v=1 %h q0", k, m_valid, m_data, m_qid, mkw(0, k));
            else npass++;
        end
        @(negedge clk);
        nchk++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_end got v=%b busy=%b need 0/0", m_valid, busy); else npass++;
    endtask

    task automatic test_round_robin();
        int base; int bad; bit ok;
        do_reset();
        for (int q = 0; q < 4; q++) push(q, 0, 20);
        for (int r = 0; r < 2; r++) for (int q = 0; q < 4; q++) exp_burst(q, r * 8, 8);
        for (int q = 0; q < 4; q++) exp_burst(q, 16, 4);
        base = rx_data.size();
        wait_rx(base + 80, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL rr_timeout got %0d words need 80", rx_data.size() - base); else npass++;
        repeat (5) @(negedge clk);
        nchk++; if (rx_data.size() - base != 80) $display("FAIL rr_count got %0d need 80", rx_data.size() - base); else npass++;
        bad = first_bad(base);
        nchk++; if (bad != -1) $display("FAIL rr_order at %0d got %h need %h", bad, rx_at(base + bad), exp_d[bad]); else npass++;
        if (ok) begin
            nchk++; if (rx_cyc[base + 1] - rx_cyc[base] != 1) $display("FAIL rr_rate got gap %0d need 1", rx_cyc[base + 1] - rx_cyc[base]); else npass++;
            nchk++; if (rx_cyc[base + 8] - rx_cyc[base + 7] != 2) $display("FAIL rr_bubble got gap %0d need 2", rx_cyc[base + 8] - rx_cyc[base + 7]); else npass++;
        end
    endtask

    task automatic test_stall();
        int base; int bad; bit ok;
        do_reset();
        push(0, 0, 10);
        exp_burst(0, 0, 8);
        exp_burst(0, 8, 2);
        base = rx_data.size();
        wait_rx(base + 3, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL stall_start_timeout got %0d words need 3", rx_data.size() - base); else npass++;
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            nchk++;
            if (m_valid !== 1'b1 || m_data !== mkw(0, 3) || m_qid !== 2'd0 || q_rd_en !== 4'h0)
                $display("FAIL stall_hold%0d got v=%b %h q%0d en=%b need v=1 %h q0 en=0000", s, m_valid, m_data, m_qid, q_rd_en, mkw(0, 3));
            else npass++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        wait_rx(base + 10, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL stall_timeout got %0d words need 10", rx_data.size() - base); else npass++;
        bad = first_bad(base);
        nchk++; if (bad != -1) $display("FAIL stall_order at %0d got %h need %h", bad, rx_at(base + bad), exp_d[bad]); else npass++;
        if (ok) begin
            nchk++; if (rx_cyc[base + 8] - rx_cyc[base + 7] != 2) $display("FAIL stall_burst_len got gap %0d need 2", rx_cyc[base + 8] - rx_cyc[base + 7]); else npass++;
        end
    endtask

    task automatic test_empty_mid_burst();
        int base; int bad; int v0; bit ok;
        do_reset();
        v0 = viol;
        push(0, 0, 10);
        push(2, 0, 3);
        push(3, 0, 2);
        exp_burst(0, 0, 8);
        exp_burst(2, 0, 3);
        exp_burst(3, 0, 2);
        exp_burst(0, 8, 2);
        base = rx_data.size();
        wait_rx(base + 15, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL empty_timeout got %0d words need 15", rx_data.size() - base); else npass++;
        repeat (4) @(negedge clk);
        bad = first_bad(base);
        nchk++; if (bad != -1) $display("FAIL empty_order at %0d got %h need %h", bad, rx_at(base + bad), exp_d[bad]); else npass++;
        nchk++; if (viol != v0) $display("FAIL empty_pop_violations got %0d need 0", viol - v0); else npass++;
    endtask

    task automatic test_mask();
        int base; int bad; bit ok;
        do_reset();
        cfg_enable = 4'b1011;
        for (int q = 0; q < 4; q++) push(q, 0, 20);
        for (int r = 0; r < 2; r++) begin
            exp_burst(0, r * 8, 8);
            exp_burst(1, r * 8, 8);
            exp_burst(3, r * 8, 8);
        end
        exp_burst(0, 16, 4);
        exp_burst(1, 16, 4);
        exp_burst(3, 16, 4);
        base = rx_data.size();
        wait_rx(base + 60, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL mask_timeout got %0d words need 60", rx_data.size() - base); else npass++;
        repeat (10) @(negedge clk);
        bad = first_bad(base);
        nchk++; if (bad != -1) $display("FAIL mask_order at %0d got %h need %h", bad, rx_at(base + bad), exp_d[bad]); else npass++;
        nchk++; if (tail[2] - head[2] != 20) $display("FAIL mask_q2_left got %0d need 20", tail[2] - head[2]); else npass++;
        nchk++; if (rx_data.size() - base != 60) $display("FAIL mask_count got %0d need 60", rx_data.size() - base); else npass++;
    endtask

    task automatic test_reset_mid_burst();
        int base; bit ok;
        do_reset();
        for (int q = 0; q < 4; q++) push(q, 0, 20);
        base = rx_data.size();
        wait_rx(base + 3, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL rstmid_start_timeout got %0d words need 3", rx_data.size() - base); else npass++;
        rst = 1'b1;
        #1;
        nchk++; if (q_rd_en !== 4'h0) $display("FAIL rstmid_pop_in_reset got %b need 0000", q_rd_en); else npass++;
        @(negedge clk);
        nchk++; if (m_valid !== 1'b0) $display("FAIL rstmid_m_valid got %b need 0", m_valid); else npass++;
        nchk++; if (q_rd_en !== 4'h0) $display("FAIL rstmid_q_rd_en got %b need 0000", q_rd_en); else npass++;
        nchk++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b need 0", busy); else npass++;
        rst = 1'b0;
        base = rx_data.size();
        wait_rx(base + 9, ok);
        nchk++; if (ok !== 1'b1) $display("FAIL rstmid_timeout got %0d words need 9", rx_data.size() - base); else npass++;
        nchk++; if (rx_at(base) !== mkw(0, 4)) $display("FAIL rstmid_first got %h need %h", rx_at(base), mkw(0, 4)); else npass++;
        nchk++; if (rx_at(base + 7) !== mkw(0, 11)) $display("FAIL rstmid_eighth got %h need %h", rx_at(base + 7), mkw(0, 11)); else npass++;
        nchk++; if (rx_at(base + 8) !== mkw(1, 0)) $display("FAIL rstmid_next_q got %h need %h", rx_at(base + 8), mkw(1, 0)); else npass++;
    endtask

    initial begin
        test_reset();
        test_single_queue();
        test_round_robin();
        test_stall();
        test_empty_mid_burst();
        test_mask();
        test_reset_mid_burst();
        nchk++; if (viol != 0) $display("FAIL queue_protocol got %0d violations need 0", viol); else npass++;
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
